hazard_scheduler: RTL and testbench

- Pipeline sequencing controller for the decode stage's register-read datapath.
- Keeps shadow copies of the instructions occupying E and M, and uses them to:
  - drive the decode stage's 2-bit forward0/forward1 selects (00 = regfile, 01 = E result, 10 = M result);
  - stall F/D and insert bubbles on load-use and multi-cycle-FPU hazards;
  - flush on taken branches.
- Sits beside the decode stage; the F/D and D/E pipeline registers obey its stall/flush outputs.

---
 rtl/hazard_scheduler.sv | 133 +++++++++++++
 tb/tb_hazard_scheduler.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// hazard_scheduler
//   Decode-stage sequencing controller. Keeps shadow copies (valid, rd,
//   regwrite, memread, fpu_mc) of the instructions that occupy E and M. From
//   them it produces the operand forwarding selects, the F/D stall, the D/E
//   bubble insertion, the branch flush and the multi-cycle FPU hold.
//
//   Optional feature macro: HAZARD_FORWARD_EN
//     defined   : E/M results are forwarded (01 = E, 10 = M). Only a load-use
//                 hazard or an FPU hold stalls.
//     undefined : forward0/forward1 are always 00. Any RAW match against E or
//                 M stalls decode until the producer has left M.
//
//   Ports
//     clk, rstn            clock; synchronous reset, active-high (1 = reset)
//     d_valid              decode holds a valid instruction
//     d_rs0/d_rs1          decode sources ({flag, 5-bit index})
//     d_use0/d_use1        the decode instruction reads rs0 / rs1
//     d_rd, d_regwrite     decode destination and its write enable
//     d_memread, d_fpu_mc  the decode instruction is a load / a multi-cycle FPU op
//     branch_taken         a branch resolved taken in E this cycle
//     forward0/forward1    operand selects (00 regfile, 01 E, 10 M)
//     stall_f, stall_d     hold PC + F/D; hold D and send a bubble into E
//     flush_d              F/D loads a bubble
//     hold_e, busy         E is occupied by an unfinished multi-cycle FPU op
module hazard_scheduler #(
  parameter int unsigned FPU_LAT  = 3,
  parameter logic [5:0]  ZERO_REG = 6'd0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       d_valid,
  input  logic [5:0] d_rs0,
  input  logic [5:0] d_rs1,
  input  logic       d_use0,
  input  logic       d_use1,
  input  logic [5:0] d_rd,
  input  logic       d_regwrite,
  input  logic       d_memread,
  input  logic       d_fpu_mc,
  input  logic       branch_taken,
  output logic [1:0] forward0,
  output logic [1:0] forward1,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       hold_e,
  output logic       busy
);

  typedef struct packed {
    logic       valid;
    logic [5:0] rd;
    logic       regwrite;
    logic       memread;
    logic       fpu_mc;
  } slot_t;

  localparam logic [3:0] LAT_M1 = 4'(FPU_LAT - 1);

  slot_t      e_q, e_d, m_q, m_d;
  logic [3:0] cnt_q, cnt_d;

  logic match_e0, match_e1, match_m0, match_m1;
  logic raw_stall, enter_e;

  // In M only the destination is ever needed; load/FPU kind matters only in E.
  logic unused_m;
  assign unused_m = m_q.memread ^ m_q.fpu_mc;

  function automatic logic raw(input logic use_s, input logic [5:0] rs,
                               input slot_t s, input logic dv);
    return use_s & dv & (rs != ZERO_REG) & s.valid & s.regwrite & (s.rd == rs);
  endfunction

  always_comb begin
    hold_e   = e_q.valid & e_q.fpu_mc & (cnt_q != 4'd0);
    match_e0 = raw(d_use0, d_rs0, e_q, d_valid);
    match_e1 = raw(d_use1, d_rs1, e_q, d_valid);
    match_m0 = raw(d_use0, d_rs0, m_q, d_valid);
    match_m1 = raw(d_use1, d_rs1, m_q, d_valid);
`ifdef HAZARD_FORWARD_EN
    // A load or an unfinished FPU op in E has no result yet: fall through to M.
    forward0  = (match_e0 & ~e_q.memread & ~hold_e) ? 2'b01 :
                match_m0                            ? 2'b10 : 2'b00;
    forward1  = (match_e1 & ~e_q.memread & ~hold_e) ? 2'b01 :
                match_m1                            ? 2'b10 : 2'b00;
    raw_stall = (match_e0 | match_e1) & (e_q.memread | hold_e);
`else
    forward0  = 2'b00;
    forward1  = 2'b00;
    raw_stall = match_e0 | match_e1 | match_m0 | match_m1;
`endif
    // A taken branch kills the decode instruction, so there is nothing to hold.
    stall_d = ~branch_taken & (raw_stall | hold_e);
    stall_f = stall_d;
    flush_d = branch_taken;
    busy    = hold_e;
    enter_e = d_valid & ~stall_d & ~branch_taken;
  end

  always_comb begin
    e_d   = e_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (hold_e) begin
      // E is frozen; its predecessor in M retires after one cycle.
      m_d   = '0;
      cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    end else begin
      m_d   = e_q;
      e_d   = '0;
      cnt_d = 4'd0;
      if (enter_e) begin
        e_d = '{valid: 1'b1, rd: d_rd, regwrite: d_regwrite,
                memread: d_memread, fpu_mc: d_fpu_mc};
        if (d_fpu_mc) cnt_d = LAT_M1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      e_q   <= '0;
      m_q   <= '0;
      cnt_q <= 4'd0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       d_valid, d_use0, d_use1, d_regwrite, d_memread, d_fpu_mc, branch_taken;
  logic [5:0] d_rs0, d_rs1, d_rd;
  logic [1:0] forward0, forward1;
  logic       stall_f, stall_d, flush_d, hold_e, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.FPU_LAT(3), .ZERO_REG(6'd0)) dut (
    .clk(clk), .rstn(rstn), .d_valid(d_valid), .d_rs0(d_rs0), .d_rs1(d_rs1),
    .d_use0(d_use0), .d_use1(d_use1), .d_rd(d_rd), .d_regwrite(d_regwrite),
    .d_memread(d_memread), .d_fpu_mc(d_fpu_mc), .branch_taken(branch_taken),
    .forward0(forward0), .forward1(forward1), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .hold_e(hold_e), .busy(busy)
  );

  task automatic cmp(input string tag, input string nm,
                     input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s observed=%b expected=%b", tag, nm, got, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] f0, input logic [1:0] f1,
                     input logic st, input logic fl, input logic he);
    cmp(tag, "forward0", forward0, f0);
    cmp(tag, "forward1", forward1, f1);
    cmp(tag, "stall_f",  {1'b0, stall_f}, {1'b0, st});
    cmp(tag, "stall_d",  {1'b0, stall_d}, {1'b0, st});
    cmp(tag, "flush_d",  {1'b0, flush_d}, {1'b0, fl});
    cmp(tag, "hold_e",   {1'b0, hold_e},  {1'b0, he});
    cmp(tag, "busy",     {1'b0, busy},    {1'b0, he});
    checks++;
    assert (!(branch_taken && hold_e)) else begin
      errors++;
      $error("FAIL %s illegal branch_taken during hold observed=1 expected=0", tag);
    end
  endtask

  // Drive one decode-cycle worth of inputs at the falling edge, then settle.
  task automatic st(input logic v, input logic [5:0] rs0, input logic [5:0] rs1,
                    input logic u0, input logic u1, input logic [5:0] rd,
                    input logic rw, input logic mr, input logic fp, input logic br);
    @(negedge clk);
    d_valid = v; d_rs0 = rs0; d_rs1 = rs1; d_use0 = u0; d_use1 = u1;
    d_rd = rd; d_regwrite = rw; d_memread = mr; d_fpu_mc = fp; branch_taken = br;
    #1;
  endtask

  task automatic idle();
    st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle", 2'b00, 2'b00, 0, 0, 0);
  endtask

  initial begin
    rstn = 1'b1;
    d_valid = 0; d_rs0 = 0; d_rs1 = 0; d_use0 = 0; d_use1 = 0;
    d_rd = 0; d_regwrite = 0; d_memread = 0; d_fpu_mc = 0; branch_taken = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset", 2'b00, 2'b00, 0, 0, 0);
    rstn = 1'b0;

    // Independent ALU ops
    st(1, 10, 11, 1, 1, 1, 1, 0, 0, 0);  chk("ind_a", 2'b00, 2'b00, 0, 0, 0);
    st(1,  3,  4, 1, 1, 2, 1, 0, 0, 0);  chk("ind_b", 2'b00, 2'b00, 0, 0, 0);
    st(1, 13, 14, 1, 1, 12, 1, 0, 0, 0); chk("ind_c", 2'b00, 2'b00, 0, 0, 0);
    st(1, 16, 17, 1, 1, 15, 1, 0, 0, 0); chk("ind_d", 2'b00, 2'b00, 0, 0, 0);

    // add x5 ; sub x6,x5,x7 ; op x22,x23,x5
    st(1, 20, 21, 1, 1, 5, 1, 0, 0, 0);  chk("add_x5", 2'b00, 2'b00, 0, 0, 0);
    st(1,  5,  7, 1, 1, 6, 1, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
    chk("fwd_e", 2'b01, 2'b00, 0, 0, 0);
    st(1, 23, 5, 1, 1, 22, 1, 0, 0, 0);  chk("fwd_m", 2'b00, 2'b10, 0, 0, 0);
`else
    chk("raw_e_stall", 2'b00, 2'b00, 1, 0, 0);
    st(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);    chk("raw_m_stall", 2'b00, 2'b00, 1, 0, 0);
    st(1, 5, 7, 1, 1, 6, 1, 0, 0, 0);    chk("raw_clear", 2'b00, 2'b00, 0, 0, 0);
    st(1, 23, 5, 1, 1, 22, 1, 0, 0, 0);  chk("after_sub", 2'b00, 2'b00, 0, 0, 0);
`endif
    idle(); idle();

    // lw x8 ; add x9,x8,x8
    st(1, 9, 0, 1, 0, 8, 1, 1, 0, 0);    chk("lw", 2'b00, 2'b00, 0, 0, 0);
    st(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);    chk("ld_use", 2'b00, 2'b00, 1, 0, 0);
    st(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
    chk("ld_fwd", 2'b10, 2'b10, 0, 0, 0);
`else
    chk("ld_m_stall", 2'b00, 2'b00, 1, 0, 0);
    st(1, 8, 8, 1, 1, 9, 1, 0, 0, 0);    chk("ld_clear", 2'b00, 2'b00, 0, 0, 0);
`endif
    idle(); idle();

    // FPU op writing f2 (34), consumer of f2
    st(1, 35, 36, 1, 1, 34, 1, 0, 1, 0); chk("fpu_issue", 2'b00, 2'b00, 0, 0, 0);
    st(1, 34, 37, 1, 0, 35, 1, 0, 0, 0); chk("fpu_hold1", 2'b00, 2'b00, 1, 0, 1);
    st(1, 34, 37, 1, 0, 35, 1, 0, 0, 0); chk("fpu_hold2", 2'b00, 2'b00, 1, 0, 1);
    st(1, 34, 37, 1, 0, 35, 1, 0, 0, 0);
`ifdef HAZARD_FORWARD_EN
    chk("fpu_rel", 2'b01, 2'b00, 0, 0, 0);
`else
    chk("fpu_rel_stall", 2'b00, 2'b00, 1, 0, 0);
    st(1, 34, 37, 1, 0, 35, 1, 0, 0, 0); chk("fpu_m_stall", 2'b00, 2'b00, 1, 0, 0);
    st(1, 34, 37, 1, 0, 35, 1, 0, 0, 0); chk("fpu_clear", 2'b00, 2'b00, 0, 0, 0);
`endif
    idle(); idle();

    // Taken branch over a would-be load-use stall; the add must not reach E.
    st(1, 9, 0, 1, 0, 8, 1, 1, 0, 0);    chk("br_lw", 2'b00, 2'b00, 0, 0, 0);
    st(1, 8, 8, 1, 1, 9, 1, 0, 0, 1);    chk("br_flush", 2'b00, 2'b00, 0, 1, 0);
    st(1, 9, 9, 1, 1, 10, 1, 0, 0, 0);   chk("br_bubble", 2'b00, 2'b00, 0, 0, 0);
    idle(); idle();

    // x0 is never a dependency
    st(1, 1, 2, 1, 1, 0, 1, 0, 0, 0);    chk("x0_wr", 2'b00, 2'b00, 0, 0, 0);
    st(1, 0, 0, 1, 1, 11, 1, 0, 0, 0);   chk("x0_e", 2'b00, 2'b00, 0, 0, 0);
    st(1, 0, 0, 1, 1, 12, 1, 0, 0, 0);   chk("x0_m", 2'b00, 2'b00, 0, 0, 0);
    idle(); idle();

    // Reset in the middle of an FPU hold
    st(1, 35, 36, 1, 1, 34, 1, 0, 1, 0); chk("rst_fpu", 2'b00, 2'b00, 0, 0, 0);
    st(1, 34, 37, 1, 0, 35, 1, 0, 0, 0); chk("rst_hold", 2'b00, 2'b00, 1, 0, 1);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); rstn = 1'b0; #1;
    chk("rst_clear", 2'b00, 2'b00, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
